// File: rtl/rotor_step_ctrl.sv
// ---------------------------------------------------------------------------
// rotor_step_ctrl
//   Stepping controller for a three-rotor (L/M/R) substitution path. On each
//   accepted keypress, all three rotor positions step at once. The controller
//   then waits a fixed number of cycles so the combinational rotor path can
//   settle. After that it presents ENC_VALID until the consumer acknowledges.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_ni         asynchronous active-low reset
//   load_i         one-cycle request to load start positions (IDLE only)
//   load_l/m/r_i   start positions; values 26..31 fold down by 26
//   key_valid_i    keypress request
//   key_ready_o    high only in IDLE
//   enc_valid_o    high only in VALID (positions stable, letter may be sampled)
//   enc_ack_i      consumer has sampled the letter (honoured only in VALID)
//   pos_l/m/r_o    registered rotor positions, always 0..25
//   key_cnt_o      keypresses accepted since reset or last LOAD (mod 2^16)
// ---------------------------------------------------------------------------
module rotor_step_ctrl #(
  parameter int NOTCH_L = 16,
  parameter int NOTCH_M = 4,
  parameter int NOTCH_R = 21,
  parameter int SETTLE  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [4:0]  load_l_i,
  input  logic [4:0]  load_m_i,
  input  logic [4:0]  load_r_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic        enc_valid_o,
  input  logic        enc_ack_i,
  output logic [4:0]  pos_l_o,
  output logic [4:0]  pos_m_o,
  output logic [4:0]  pos_r_o,
  output logic [15:0] key_cnt_o
);

  // The left-rotor notch has no effect on stepping: there is no fourth rotor
  // for it to carry into. It is still range-checked with the others so that a
  // bad configuration fails at elaboration.
  if (NOTCH_L < 0 || NOTCH_L > 25 || NOTCH_M < 0 || NOTCH_M > 25 ||
      NOTCH_R < 0 || NOTCH_R > 25 || SETTLE < 1 || SETTLE > 15) begin : g_bad_params
    $fatal(1, "rotor_step_ctrl: parameter out of range");
  end

  localparam logic [4:0] NOTCH_M_C = 5'(NOTCH_M);
  localparam logic [4:0] NOTCH_R_C = 5'(NOTCH_R);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  pos_l_q, pos_l_d;
  logic [4:0]  pos_m_q, pos_m_d;
  logic [4:0]  pos_r_q, pos_r_d;
  logic [15:0] key_cnt_q, key_cnt_d;

  logic load_acc;
  logic key_acc;
  logic step_m;
  logic step_l;

  // Fold an out-of-range 5-bit load value (26..31) back into 0..25.
  function automatic logic [4:0] fold26(input logic [4:0] v);
    return (v > 5'd25) ? (v - 5'd26) : v;
  endfunction

  // Modulo-26 increment.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : (v + 5'd1);
  endfunction

  // LOAD has priority over a same-cycle key; the key is dropped, not queued.
  assign load_acc = (state_q == ST_IDLE) && load_i;
  assign key_acc  = (state_q == ST_IDLE) && key_valid_i && !load_i;

  // Double-stepping: the middle rotor also steps when it sits on its own
  // notch, which is the same condition that carries into the left rotor.
  assign step_m = (pos_r_q == NOTCH_R_C) || (pos_m_q == NOTCH_M_C);
  assign step_l = (pos_m_q == NOTCH_M_C);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (key_acc) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_VALID;
      ST_VALID:  if (enc_ack_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    key_ready_o = (state_q == ST_IDLE);
    enc_valid_o = (state_q == ST_VALID);
  end

  // Datapath next-state: positions only change on LOAD or key accept, so they
  // hold through SETTLE and VALID.
  always_comb begin
    pos_l_d   = pos_l_q;
    pos_m_d   = pos_m_q;
    pos_r_d   = pos_r_q;
    key_cnt_d = key_cnt_q;
    cnt_d     = cnt_q;
    if (load_acc) begin
      pos_l_d   = fold26(load_l_i);
      pos_m_d   = fold26(load_m_i);
      pos_r_d   = fold26(load_r_i);
      key_cnt_d = 16'd0;
    end else if (key_acc) begin
      pos_r_d   = inc26(pos_r_q);
      if (step_m) pos_m_d = inc26(pos_m_q);
      if (step_l) pos_l_d = inc26(pos_l_q);
      key_cnt_d = key_cnt_q + 16'd1;
      cnt_d     = SETTLE_LD;
    end else if (state_q == ST_SETTLE && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_l_q   <= 5'd0;
      pos_m_q   <= 5'd0;
      pos_r_q   <= 5'd0;
      key_cnt_q <= 16'd0;
      cnt_q     <= 4'd0;
    end else begin
      pos_l_q   <= pos_l_d;
      pos_m_q   <= pos_m_d;
      pos_r_q   <= pos_r_d;
      key_cnt_q <= key_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pos_l_o   = pos_l_q;
  assign pos_m_o   = pos_m_q;
  assign pos_r_o   = pos_r_q;
  assign key_cnt_o = key_cnt_q;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rotor_step_ctrl
//   Directed bench for rotor_step_ctrl with default parameters
//   (NOTCH_M=4, NOTCH_R=21, SETTLE=2). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_rotor_step_ctrl;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        load;
  logic [4:0]  load_l, load_m, load_r;
  logic        key_valid;
  logic        key_ready;
  logic        enc_valid;
  logic        enc_ack;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic [15:0] key_cnt;

  int n_assert;
  int n_fail;

  rotor_step_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .load_l_i    (load_l),
    .load_m_i    (load_m),
    .load_r_i    (load_r),
    .key_valid_i (key_valid),
    .key_ready_o (key_ready),
    .enc_valid_o (enc_valid),
    .enc_ack_i   (enc_ack),
    .pos_l_o     (pos_l),
    .pos_m_o     (pos_m),
    .pos_r_o     (pos_r),
    .key_cnt_o   (key_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pos3(input int l, input int m, input int r);
    return {17'd0, 5'(l), 5'(m), 5'(r)};
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until enc_valid is seen; returns the number of edges taken, or -1.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (enc_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // One full keypress with enc_ack held high: accept, settle, valid, back to IDLE.
  task automatic press(input string tag);
    int lat;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    step();
    chk({tag, "_idle"}, {31'd0, key_ready}, 32'd1);
  endtask

  task automatic do_load(input int l, input int m, input int r);
    load   = 1'b1;
    load_l = 5'(l);
    load_m = 5'(m);
    load_r = 5'(r);
    step();
    load   = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen;
    n_assert  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    clk_en    = 1'b0;
    rst_n     = 1'b1;
    load      = 1'b0;
    load_l    = 5'd0;
    load_m    = 5'd0;
    load_r    = 5'd0;
    key_valid = 1'b0;
    enc_ack   = 1'b1;

    // Reset pulse with the clock stopped: outputs must respond asynchronously.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pos",   pos3(pos_l, pos_m, pos_r), pos3(0, 0, 0));
    chk("rst_ready", {31'd0, key_ready}, 32'd1);
    chk("rst_valid", {31'd0, enc_valid}, 32'd0);
    chk("rst_cnt",   {16'd0, key_cnt}, 32'd0);
    #2 rst_n = 1'b1;

    // First edge after reset release accepts a key.
    key_valid = 1'b1;
    clk_en    = 1'b1;
    step();
    key_valid = 1'b0;
    chk("first_pos",   pos3(pos_l, pos_m, pos_r), pos3(0, 0, 1));
    chk("first_cnt",   {16'd0, key_cnt}, 32'd1);
    chk("first_ready", {31'd0, key_ready}, 32'd0);
    wait_valid(lat);
    chk("first_lat", 32'(lat), 32'd2);
    step();

    // Double step sequence.
    do_load(0, 3, 20);
    chk("ld_pos",   pos3(pos_l, pos_m, pos_r), pos3(0, 3, 20));
    chk("ld_cnt",   {16'd0, key_cnt}, 32'd0);
    press("ds1");
    chk("ds1_pos", pos3(pos_l, pos_m, pos_r), pos3(0, 3, 21));
    press("ds2");
    chk("ds2_pos", pos3(pos_l, pos_m, pos_r), pos3(0, 4, 22));
    press("ds3");
    chk("ds3_pos", pos3(pos_l, pos_m, pos_r), pos3(1, 5, 23));
    chk("ds_cnt",  {16'd0, key_cnt}, 32'd3);

    // Wrap and out-of-range load.
    do_load(25, 25, 31);
    chk("oor_pos", pos3(pos_l, pos_m, pos_r), pos3(25, 25, 5));
    press("oor");
    chk("oor_step", pos3(pos_l, pos_m, pos_r), pos3(25, 25, 6));
    do_load(0, 0, 25);
    press("wrap");
    chk("wrap_pos", pos3(pos_l, pos_m, pos_r), pos3(0, 0, 0));

    // LOAD and KEY_VALID together: load wins, key dropped.
    key_valid = 1'b1;
    do_load(2, 2, 2);
    key_valid = 1'b0;
    chk("cf_pos",   pos3(pos_l, pos_m, pos_r), pos3(2, 2, 2));
    chk("cf_cnt",   {16'd0, key_cnt}, 32'd0);
    chk("cf_ready", {31'd0, key_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (enc_valid !== 1'b0) seen = 1'b1;
    end
    chk("cf_novalid", {31'd0, seen}, 32'd0);

    // Backpressure: enc_ack low, extra key/load ignored.
    enc_ack   = 1'b0;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("bp_acc_valid", {31'd0, enc_valid}, 32'd0);
    step();
    chk("bp_e1_valid", {31'd0, enc_valid}, 32'd0);
    step();
    chk("bp_e2_valid", {31'd0, enc_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      key_valid = 1'b1;
      load      = 1'b1;
      load_l    = 5'd7;
      load_m    = 5'd7;
      load_r    = 5'd7;
      step();
      chk("bp_hold_valid", {31'd0, enc_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, key_ready}, 32'd0);
      chk("bp_hold_pos",   pos3(pos_l, pos_m, pos_r), pos3(2, 2, 3));
      chk("bp_hold_cnt",   {16'd0, key_cnt}, 32'd1);
    end
    key_valid = 1'b0;
    load      = 1'b0;
    enc_ack   = 1'b1;
    step();
    chk("bp_rel_valid", {31'd0, enc_valid}, 32'd0);
    chk("bp_rel_ready", {31'd0, key_ready}, 32'd1);
    chk("bp_rel_pos",   pos3(pos_l, pos_m, pos_r), pos3(2, 2, 3));

    // Reset during SETTLE aborts the keypress.
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("ab_settle", {31'd0, key_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_pos",   pos3(pos_l, pos_m, pos_r), pos3(0, 0, 0));
    chk("ab_ready", {31'd0, key_ready}, 32'd1);
    chk("ab_valid", {31'd0, enc_valid}, 32'd0);
    chk("ab_cnt",   {16'd0, key_cnt}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (enc_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (enc_valid !== 1'b0) seen = 1'b1;
    end
    chk("ab_novalid", {31'd0, seen}, 32'd0);
    chk("ab_idle",    {31'd0, key_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor_step_ctrl.md
ROTOR_STEP_CTRL -- requirements
Module: rotor_step_ctrl

Interface
REQ-001 Parameter NOTCH_L, default 16, meaning left-rotor turnover position; range 0..25.
REQ-002 Parameter NOTCH_M, default 4, meaning middle-rotor turnover position; range 0..25.
REQ-003 Parameter NOTCH_R, default 21, meaning right-rotor turnover position; range 0..25.
REQ-004 Parameter SETTLE, default 2, meaning cycles allowed for the combinational rotor path to settle; range 1..15.
REQ-005 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RSTN  in  1  reset, asynchronous and active-low.
REQ-007 LOAD  in  1  one-cycle request to load start positions.
REQ-008 LOAD_L / LOAD_M / LOAD_R  in  5 each  start positions sampled when LOAD is accepted.
REQ-009 KEY_VALID  in  1  keypress request.
REQ-010 KEY_READY  out  1  controller can accept a keypress.
REQ-011 ENC_VALID  out  1  stepped positions are stable and the encoded letter may be sampled.
REQ-012 ENC_ACK  in  1  consumer has sampled the encoded letter.
REQ-013 POS_L / POS_M / POS_R  out  5 each  registered rotor positions (0..25) driving the rotor POS inputs.
REQ-014 KEY_CNT  out  16  keypresses accepted since reset or last LOAD.

Function
REQ-015 States: IDLE, SETTLE, VALID; encoding is free.
REQ-016 KEY_READY SHALL be 1 only in IDLE; ENC_VALID SHALL be 1 only in VALID.
REQ-017 LOAD is accepted only in IDLE; in SETTLE or VALID it SHALL be ignored.
REQ-018 On an accepted LOAD: each position := load value if <=25, else load value-26; KEY_CNT := 0; state stays IDLE.
REQ-019 A keypress is accepted when KEY_VALID=1, KEY_READY=1 and LOAD=0; LOAD wins a same-cycle conflict and the key is dropped, not queued.
REQ-020 On the accept edge, all positions SHALL step simultaneously, using pre-step values: R := R+1; M := M+1 if R==NOTCH_R or M==NOTCH_M; L := L+1 if M==NOTCH_M.
REQ-021 Every increment SHALL wrap 25 -> 0; positions SHALL never leave 0..25.
REQ-022 On the accept edge, KEY_CNT SHALL increment modulo 2^16, and state SHALL go to SETTLE with the settle counter loaded to SETTLE-1.
REQ-023 In SETTLE, the counter decrements each cycle; at 0, state SHALL go to VALID on the next edge, so ENC_VALID is first high SETTLE cycles after the accept edge.
REQ-024 Positions SHALL hold constant throughout SETTLE and VALID.
REQ-025 In VALID, ENC_VALID SHALL hold until ENC_ACK=1, which returns the state to IDLE on that edge; ENC_ACK outside VALID SHALL be ignored.
REQ-026 Peak throughput is one keypress per SETTLE+2 cycles with ENC_ACK held high.

Reset
REQ-027 While RSTN=0: POS_L/M/R=0, KEY_CNT=0, settle counter=0, state=IDLE, KEY_READY=1, ENC_VALID=0, independent of CLK.
REQ-028 Reset asserted in any state, including SETTLE or VALID, SHALL abort the keypress with no ENC_VALID pulse.
REQ-029 After RSTN deasserts, the first accept SHALL be possible on the first rising CLK edge.

Verification
REQ-030 Reset: pulse RSTN low mid-cycle with no clock -> POS=0/0/0, KEY_READY=1, ENC_VALID=0, KEY_CNT=0.
REQ-031 Double step: LOAD 0/3/20, three keys with ENC_ACK tied high -> positions 0/3/21, then 0/4/22, then 1/5/23; KEY_CNT=3.
REQ-032 Wrap and out-of-range load: LOAD 25/25/31 -> 25/25/5; one key -> 25/25/6; LOAD 0/0/25 then one key -> 0/0/0.
REQ-033 Conflict: LOAD 2/2/2 and KEY_VALID in the same IDLE cycle -> positions 2/2/2, KEY_CNT=0, no ENC_VALID pulse.
REQ-034 Backpressure: SETTLE=2, hold ENC_ACK low for 10 cycles after ENC_VALID -> ENC_VALID rises exactly 2 cycles after the accept edge and stays high; KEY_READY=0; extra KEY_VALID and LOAD are ignored; positions are unchanged.
REQ-035 Abort: assert RSTN low during SETTLE -> immediate 0/0/0 and IDLE; no ENC_VALID pulse.
